note_player: RTL and testbench
==============================

NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 The block SHALL have parameter NOTE_WIDTH, default 6, giving the width of the note code.
REQ-002 The block SHALL have parameter DURATION_WIDTH, default 6, giving the width of the duration in beats.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port play, input, 1 bit: 1 runs the note, 0 pauses it.
REQ-006 The block SHALL have port beat, input, 1 bit: one-cycle duration-tick strobe.
REQ-007 The block SHALL have port load_new_note, input, 1 bit: one-cycle strobe; note and duration are valid only in this cycle.
REQ-008 The block SHALL have port note, input, NOTE_WIDTH bits: note code; 0 means rest.
REQ-009 The block SHALL have port duration, input, DURATION_WIDTH bits: note length in beats.
REQ-010 The block SHALL have port note_out, output, NOTE_WIDTH bits: the note currently sounding; 0 means silent.
REQ-011 The block SHALL have port active, output, 1 bit: 1 while a note is held (states PLAYING and FINISH).
REQ-012 The block SHALL have port beats_left, output, DURATION_WIDTH bits: the remaining beat count.
REQ-013 The block SHALL have port note_done, output, 1 bit: one-cycle pulse at the end of a note.

Function
REQ-014 The block SHALL implement the FSM states IDLE, PLAYING and FINISH, held in a registered state vector.
REQ-015 In IDLE, a load_new_note with duration!=0 SHALL latch note and duration and enter PLAYING on the next edge; note_out is valid 1 cycle after the load.
REQ-016 In IDLE, a load_new_note with duration==0 SHALL latch nothing and enter FINISH on the next edge.
REQ-017 In PLAYING, each cycle with beat&&play SHALL decrement beats_left by 1.
REQ-018 In PLAYING, beat&&play with beats_left==1 SHALL set beats_left to 0 and enter FINISH.
REQ-019 note_done SHALL equal (state==FINISH); FINISH SHALL last exactly 1 cycle and then go to IDLE unless REQ-023 applies.
REQ-020 In FINISH and IDLE, note_out SHALL be 0.
REQ-021 While play==0, beats_left and the latched note SHALL be frozen, note_out SHALL be 0, and state and active SHALL be unchanged.
REQ-022 A load_new_note in PLAYING SHALL preempt the current note: it reloads note and beats_left, no note_done is produced for the old note, and the block stays in PLAYING.
REQ-022a A preempting load with duration==0 SHALL go to FINISH instead.
REQ-023 A load_new_note in FINISH SHALL still give the current note_done pulse, latch the new note, and go to PLAYING (or FINISH if duration==0).
REQ-024 When load_new_note and the final beat occur in the same cycle, the load SHALL take priority and no note_done pulse SHALL be produced.
REQ-025 load_new_note SHALL be accepted regardless of play; while play==0 the loaded note stays muted until play returns to 1.
REQ-026 A rest (note==0) SHALL be timed exactly like a note, with note_out held at 0.
REQ-027 beats_left SHALL never wrap below 0; a beat in IDLE or FINISH SHALL have no effect.
REQ-028 All outputs SHALL be registered or derived only from registered state and play, with no combinational path from load_new_note, note or duration to any output.

Reset
REQ-029 reset_n==0 SHALL asynchronously force state=IDLE, note_out=0, beats_left=0, active=0, note_done=0, and clear the latched note.
REQ-030 A reset asserted mid-note SHALL abandon the note with no note_done pulse; after release the block SHALL accept a load on the first rising edge.

Verification
REQ-031 The bench SHALL cover: load note=12, dur=3, play=1, beat every 4 cycles -> note_out=12 from the cycle after the load; beats_left 3,2,1,0; one note_done pulse the cycle after the 3rd beat; then IDLE and note_out=0.
REQ-032 The bench SHALL cover: dur=2 with play dropped for 10 cycles between beats, and beats during the pause -> beats_left is held and note_out=0 during the pause; note_done after 2 beats counted only while play==1.
REQ-033 The bench SHALL cover: load note=5, dur=4; after 1 beat, load note=9, dur=2 -> note_out=9, beats_left=2, no note_done for note 5; note_done after 2 more beats.
REQ-034 The bench SHALL cover: load with dur=0 -> note_done high exactly 1 cycle later, note_out stays 0; and a load on the same cycle as the final beat -> no note_done, new note plays.
REQ-035 The bench SHALL cover: reset_n driven low asynchronously between edges while beats_left=3 -> all outputs 0 immediately, no note_done.
REQ-036 The bench SHALL cover: a rest (note=0, dur=2) -> active=1, note_out=0, note_done after 2 beats.

Source files
------------

// File: rtl/note_player.sv
// Note sequencer: latches a note and its beat count, counts beats down while play is high,
// and pulses note_done for one cycle when the note runs out.
module note_player #(
    parameter int NOTE_WIDTH     = 6,
    parameter int DURATION_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      play,
    input  logic                      beat,
    input  logic                      load_new_note,
    input  logic [NOTE_WIDTH-1:0]     note,
    input  logic [DURATION_WIDTH-1:0] duration,
    output logic [NOTE_WIDTH-1:0]     note_out,
    output logic                      active,
    output logic [DURATION_WIDTH-1:0] beats_left,
    output logic                      note_done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PLAYING = 2'd1;
    localparam logic [1:0] FINISH  = 2'd2;

    logic [1:0]            state;
    logic [NOTE_WIDTH-1:0] note_q;

    // A load wins over everything else, including the final beat of the current note.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            note_q     <= '0;
            beats_left <= '0;
        end else if (load_new_note) begin
            if (duration != '0) begin
                state      <= PLAYING;
                note_q     <= note;
                beats_left <= duration;
            end else begin
                state      <= FINISH;
                beats_left <= '0;
            end
        end else begin
            case (state)
                PLAYING: begin
                    if (beat && play) begin
                        if (beats_left == DURATION_WIDTH'(1)) begin
                            beats_left <= '0;
                            state      <= FINISH;
                        end else begin
                            beats_left <= beats_left - DURATION_WIDTH'(1);
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Pausing only mutes the output; the latched note is kept for when play returns.
    assign note_out  = (state == PLAYING && play) ? note_q : '0;
    assign active    = (state == PLAYING) || (state == FINISH);
    assign note_done = (state == FINISH);

endmodule

// File: tb/tb_note_player.sv
// Directed and random bench for note_player against a note-level reference model.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       play = 1'b0;
    logic       beat = 1'b0;
    logic       load_new_note = 1'b0;
    logic [5:0] note = '0;
    logic [5:0] duration = '0;
    logic [5:0] note_out;
    logic       active;
    logic [5:0] beats_left;
    logic       note_done;

    int tests = 0;
    int fails = 0;

    // Reference model: the note being held, its remaining beats, and whether it just ended.
    bit       m_on;
    bit       m_done;
    int       m_left;
    int       m_note;
    int       done_count;

    note_player #(.NOTE_WIDTH(6), .DURATION_WIDTH(6)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .beat(beat),
        .load_new_note(load_new_note), .note(note), .duration(duration),
        .note_out(note_out), .active(active), .beats_left(beats_left),
        .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_done = 0; m_left = 0; m_note = 0;
    endtask

    task automatic model_edge(input bit p, input bit b, input bit ld, input int n, input int d);
        bit ended;
        ended = 0;
        if (ld) begin
            if (d != 0) begin
                m_on = 1; m_note = n; m_left = d;
            end else begin
                m_on = 0; m_left = 0; ended = 1;
            end
        end else if (m_on && b && p) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_on = 0; ended = 1;
            end
        end
        m_done = ended;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".note_out"},   int'(note_out),   (m_on && play) ? m_note : 0);
        chk({tag, ".active"},     int'(active),     int'(m_on || m_done));
        chk({tag, ".beats_left"}, int'(beats_left), m_left);
        chk({tag, ".note_done"},  int'(note_done),  int'(m_done));
        if (note_done === 1'b1) done_count++;
    endtask

    task automatic step(input string tag, input bit p, input bit b, input bit ld,
                        input int n, input int d);
        play = p; beat = b; load_new_note = ld;
        note = 6'(n); duration = 6'(d);
        @(posedge clk);
        model_edge(p, b, ld, n, d);
        #1;
        check_model(tag);
        beat = 0; load_new_note = 0;
    endtask

    task automatic idle_steps(input string tag, input bit p, input int k);
        for (int i = 0; i < k; i++) step(tag, p, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("reset.note_out", int'(note_out), 0);
        chk("reset.active", int'(active), 0);
        chk("reset.beats_left", int'(beats_left), 0);
        chk("reset.note_done", int'(note_done), 0);
        #5 reset_n = 1'b1;

        // Basic note: 12 for 3 beats, beat every 4 cycles.
        done_count = 0;
        step("basic_load", 1, 0, 1, 12, 3);
        chk("basic_first_note", int'(note_out), 12);
        for (int k = 0; k < 3; k++) begin
            idle_steps("basic_wait", 1, 3);
            step("basic_beat", 1, 1, 0, 0, 0);
        end
        chk("basic_done_pulse", int'(note_done), 1);
        step("basic_idle", 1, 0, 0, 0, 0);
        chk("basic_silent", int'(note_out), 0);
        chk("basic_one_done", done_count, 1);

        // Pause between beats; beats during the pause must not count.
        done_count = 0;
        step("pause_load", 1, 0, 1, 20, 2);
        step("pause_beat1", 1, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) step("pause_hold", 0, (k % 3) == 0, 0, 0, 0);
        chk("pause_held_left", int'(beats_left), 1);
        chk("pause_muted", int'(note_out), 0);
        step("pause_resume", 1, 0, 0, 0, 0);
        step("pause_beat2", 1, 1, 0, 0, 0);
        step("pause_idle", 1, 0, 0, 0, 0);
        chk("pause_one_done", done_count, 1);

        // Preemption: note 5 replaced by note 9 after one beat.
        done_count = 0;
        step("pre_load5", 1, 0, 1, 5, 4);
        step("pre_beat", 1, 1, 0, 0, 0);
        step("pre_load9", 1, 0, 1, 9, 2);
        chk("pre_note9", int'(note_out), 9);
        chk("pre_left2", int'(beats_left), 2);
        chk("pre_no_done", done_count, 0);
        step("pre_beat_a", 1, 1, 0, 0, 0);
        step("pre_beat_b", 1, 1, 0, 0, 0);
        chk("pre_done", int'(note_done), 1);
        step("pre_idle", 1, 0, 0, 0, 0);

        // Zero-duration load, then a load coinciding with the final beat.
        step("zero_load", 1, 0, 1, 33, 0);
        chk("zero_done", int'(note_done), 1);
        chk("zero_silent", int'(note_out), 0);
        step("zero_after", 1, 0, 0, 0, 0);
        done_count = 0;
        step("coinc_load", 1, 0, 1, 14, 1);
        step("coinc_beat_load", 1, 1, 1, 22, 2);
        chk("coinc_new_note", int'(note_out), 22);
        chk("coinc_no_done", done_count, 0);
        step("coinc_b1", 1, 1, 0, 0, 0);
        step("coinc_b2", 1, 1, 0, 0, 0);
        step("coinc_idle", 1, 0, 0, 0, 0);

        // Load in FINISH, then asynchronous reset mid-note with three beats left.
        step("fin_load1", 1, 0, 1, 3, 1);
        step("fin_beat", 1, 1, 0, 0, 0);
        step("fin_reload", 1, 0, 1, 40, 3);
        chk("fin_left3", int'(beats_left), 3);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_note_out", int'(note_out), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_beats_left", int'(beats_left), 0);
        chk("rst_note_done", int'(note_done), 0);
        #2 reset_n = 1'b1;
        step("rst_first_load", 1, 0, 1, 17, 2);
        chk("rst_load_taken", int'(note_out), 17);
        step("rst_b1", 1, 1, 0, 0, 0);
        step("rst_b2", 1, 1, 0, 0, 0);

        // Rest: timed like a note but silent.
        step("rest_load", 1, 0, 1, 0, 2);
        chk("rest_active", int'(active), 1);
        chk("rest_silent", int'(note_out), 0);
        step("rest_b1", 1, 1, 0, 0, 0);
        step("rest_b2", 1, 1, 0, 0, 0);
        chk("rest_done", int'(note_done), 1);
        step("rest_idle", 1, 0, 0, 0, 0);

        // Load while paused stays muted until play returns.
        step("mute_load", 0, 0, 1, 11, 2);
        chk("mute_silent", int'(note_out), 0);
        step("mute_play", 1, 0, 0, 0, 0);
        chk("mute_sounds", int'(note_out), 11);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit rp, rb, rl;
            rp = ($urandom_range(0, 99) < 80);
            rb = ($urandom_range(0, 99) < 35);
            rl = ($urandom_range(0, 99) < 12);
            step("rand", rp, rb, rl, int'($urandom_range(0, 63)), int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
